fifo_sync_prog: RTL



---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_ram.sv | 28 ++
 rtl/fifo_sync_prog.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock programmable FIFO.
// Latency: n/a (elaboration-time only).
// Backpressure: n/a.
package fifo_pkg;

    // Read-mode selector values for the FWFT parameter.
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Number of words for a given address width.
    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // True when a threshold lies inside [lo, hi]; used for elaboration checks.
    function automatic bit fifo_thresh_ok(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Latency: write lands at the clock edge; read data follows i_rd_addr combinationally.
// Backpressure: none; the caller decides when a write is legal.
// Ports: i_clk, i_wr_en/i_wr_addr/i_wr_dat (write), i_rd_addr -> o_rd_dat (read).
module fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_dat,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_dat
);

    // Contents are deliberately not reset.
    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with programmable almost-full/empty, sticky error flags, STD or FWFT read.
// Latency: STD read data one cycle after i_rd; FWFT head visible the cycle after its write edge.
// Backpressure: writes while o_full and reads while o_empty are dropped and flagged sticky.
// Ports: i_clk/i_rstn, write i_wr/i_data, read i_rd -> o_data/o_valid, i_clr_err,
//        status o_fill/o_full/o_empty/o_almost_full/o_almost_empty, errors o_overflow/o_underflow.
module fifo_sync_prog
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 4,
    parameter int FWFT          = FIFO_MODE_STD,
    parameter int AFULL_THRESH  = fifo_depth(ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_wr,
    input  logic                  i_rd,
    input  logic                  i_clr_err,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic [ADDR_WIDTH:0]   o_fill,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] L_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] L_AFULL = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] L_AEMPTY = AEMPTY_THRESH[ADDR_WIDTH:0];

    if (!fifo_thresh_ok(AFULL_THRESH, 1, DEPTH)) begin : g_bad_afull
        $fatal(1, "fifo_sync_prog: AFULL_THRESH out of range 1..DEPTH");
    end
    if (!fifo_thresh_ok(AEMPTY_THRESH, 0, DEPTH - 1)) begin : g_bad_aempty
        $fatal(1, "fifo_sync_prog: AEMPTY_THRESH out of range 0..DEPTH-1");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
        $fatal(1, "fifo_sync_prog: FWFT must be 0 or 1");
    end

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_fill;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [ADDR_WIDTH:0]   w_fill_next;
    logic [DATA_WIDTH-1:0] w_ram_dat;

    // Acceptance uses registered flags only, so a read in the same cycle
    // never frees room for a write to a full FIFO, and an empty FIFO never
    // lets a read bypass a simultaneous write.
    assign w_wr_en     = i_wr & ~r_full;
    assign w_rd_en     = i_rd & ~r_empty;
    assign w_fill_next = r_fill + (ADDR_WIDTH+1)'(w_wr_en) - (ADDR_WIDTH+1)'(w_rd_en);

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wptr),
        .i_wr_dat  (i_data),
        .i_rd_addr (r_rptr),
        .o_rd_dat  (w_ram_dat)
    );

    // Every status flag is registered from w_fill_next so it is exact right
    // after the edge; full/empty never come from pointer comparison.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_fill      <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_en) r_wptr <= r_wptr + 1'b1;
            if (w_rd_en) r_rptr <= r_rptr + 1'b1;
            r_fill   <= w_fill_next;
            r_full   <= (w_fill_next == L_DEPTH);
            r_empty  <= (w_fill_next == '0);
            r_afull  <= (w_fill_next >= L_AFULL);
            r_aempty <= (w_fill_next <= L_AEMPTY);
            // A new violation in the clear cycle keeps the flag set.
            r_overflow  <= (i_wr & r_full)  | (r_overflow  & ~i_clr_err);
            r_underflow <= (i_rd & r_empty) | (r_underflow & ~i_clr_err);
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign o_data  = w_ram_dat;
        assign o_valid = ~r_empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] r_data;
        logic                  r_valid;

        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_rd_en;
                if (w_rd_en) r_data <= w_ram_dat;
            end
        end

        assign o_data  = r_data;
        assign o_valid = r_valid;
    end

    assign o_fill         = r_fill;
    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_almost_full  = r_afull;
    assign o_almost_empty = r_aempty;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule
